// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared types and geometry helpers for the line-to-word memory bridge
package mem_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int TMO_MIN_WIDTH = 8;

   function automatic int beats_f(input int line_bytes, input int data_width);
      return line_bytes / (data_width / 8);
   endfunction

   function automatic int off_width_f(input int line_bytes);
      return (line_bytes > 1) ? $clog2(line_bytes) : 1;
   endfunction

endpackage

// File: rtl/mem_line_bridge.sv
// rtl/mem_line_bridge.sv - splits cache line reads/writes into sequential word-memory beats
module mem_line_bridge
   import mem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int LINE_BYTES     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      line_req_valid,
   input  logic                      line_req_rw,
   input  logic [ADDR_WIDTH-1:0]     line_req_addr,
   input  logic [LINE_BYTES*8-1:0]   line_req_wdata,
   output logic                      line_req_ready,
   output logic                      line_resp_valid,
   output logic [LINE_BYTES*8-1:0]   line_resp_rdata,
   output logic                      line_resp_err,
   output logic                      wmem_req_valid,
   input  logic                      wmem_req_ready,
   output logic                      wmem_req_rw,
   output logic [ADDR_WIDTH-1:0]     wmem_req_addr,
   output logic [DATA_WIDTH-1:0]     wmem_req_wdata,
   input  logic                      wmem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     wmem_resp_rdata
);

   localparam int LINE_WIDTH = LINE_BYTES * 8;
   localparam int BEATS      = beats_f(LINE_BYTES, DATA_WIDTH);
   localparam int OFF_W      = off_width_f(LINE_BYTES);
   localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TMO_NEED   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TMO_W      = (TMO_NEED > TMO_MIN_WIDTH) ? TMO_NEED : TMO_MIN_WIDTH;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [BEAT_W-1:0]       beat_q;
   logic [TMO_W-1:0]        tmo_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic                    rw_q;
   logic [LINE_WIDTH-1:0]   wdata_q;
   logic [LINE_WIDTH-1:0]   buf_q, buf_d;
   logic                    err_q;
   logic                    accept;
   logic                    resp_take;
   logic                    tmo_hit;
   logic                    tmo_abort;

   assign accept    = line_req_valid && line_req_ready;
   assign resp_take = (state_q == ST_WAIT) && wmem_resp_valid;
   assign tmo_hit   = (tmo_q == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A beat that makes progress on its final allowed cycle is not aborted.
   always_comb begin
      state_d   = state_q;
      tmo_abort = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (wmem_req_ready) begin
               state_d = ST_WAIT;
            end else if (tmo_hit) begin
               state_d   = ST_DONE;
               tmo_abort = 1'b1;
            end
         end
         ST_WAIT: begin
            if (wmem_resp_valid) begin
               state_d = (beat_q == LAST_BEAT) ? ST_DONE : ST_ISSUE;
            end else if (tmo_hit) begin
               state_d   = ST_DONE;
               tmo_abort = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      line_resp_valid = (state_q == ST_DONE);
      line_resp_err   = (state_q == ST_DONE) && err_q;
      wmem_req_valid  = (state_q == ST_ISSUE);
   end

   assign wmem_req_rw    = rw_q;
   assign wmem_req_addr  = base_q + (ADDR_WIDTH'(beat_q) << WORD_SHIFT);
   assign wmem_req_wdata = wdata_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      buf_d = buf_q;
      if (resp_take && !rw_q) begin
         buf_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] = wmem_resp_rdata;
      end
   end

   // Assembly happens in buf_q so the visible line only changes when a read finishes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_req_ready  <= 1'b0;
         line_resp_rdata <= '0;
         beat_q          <= '0;
         tmo_q           <= '0;
         base_q          <= '0;
         rw_q            <= 1'b0;
         wdata_q         <= '0;
         buf_q           <= '0;
         err_q           <= 1'b0;
      end else begin
         line_req_ready <= (state_d == ST_IDLE);
         buf_q          <= buf_d;

         if (accept) begin
            base_q  <= {line_req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            rw_q    <= line_req_rw;
            wdata_q <= line_req_wdata;
            beat_q  <= '0;
            err_q   <= 1'b0;
         end else if (resp_take && (beat_q != LAST_BEAT)) begin
            beat_q <= beat_q + 1'b1;
         end

         if (tmo_abort) begin
            err_q <= 1'b1;
         end

         if (state_d != state_q) begin
            tmo_q <= '0;
         end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) begin
            tmo_q <= tmo_q + 1'b1;
         end

         if ((state_d == ST_DONE) && (state_q != ST_DONE) && !rw_q) begin
            line_resp_rdata <= buf_d;
         end
      end
   end

endmodule

// File: tb/tb_mem_line_bridge.sv
// tb/tb_mem_line_bridge.sv - directed self-checking bench for mem_line_bridge
module tb_mem_line_bridge;

   logic          clk;
   logic          rst_n;
   logic          line_req_valid;
   logic          line_req_rw;
   logic [31:0]   line_req_addr;
   logic [127:0]  line_req_wdata;
   logic          line_req_ready;
   logic          line_resp_valid;
   logic [127:0]  line_resp_rdata;
   logic          line_resp_err;
   logic          wmem_req_valid;
   logic          wmem_req_ready;
   logic          wmem_req_rw;
   logic [31:0]   wmem_req_addr;
   logic [31:0]   wmem_req_wdata;
   logic          wmem_resp_valid;
   logic [31:0]   wmem_resp_rdata;

   int total = 0;
   int bad   = 0;

   // word-memory model controls and logs
   int            beat_idx      = 0;
   int            stall_beat    = -1;
   int            stall_left    = 0;
   int            suppress_beat = -1;
   bit            inj_idle      = 0;
   bit            inj_issue     = 0;
   bit            hs_coming     = 0;
   logic [31:0]   hs_addr       = '0;
   int            hs_beat       = 0;
   logic [31:0]   log_addr[$];
   logic [31:0]   log_data[$];
   logic          log_rw[$];
   logic [31:0]   stall_addr[$];

   int            lat;
   logic          got_err;
   logic [127:0]  got_rdata;

   mem_line_bridge #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .LINE_BYTES    (16),
      .TIMEOUT_CYCLES(10)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .line_req_valid (line_req_valid),
      .line_req_rw    (line_req_rw),
      .line_req_addr  (line_req_addr),
      .line_req_wdata (line_req_wdata),
      .line_req_ready (line_req_ready),
      .line_resp_valid(line_resp_valid),
      .line_resp_rdata(line_resp_rdata),
      .line_resp_err  (line_resp_err),
      .wmem_req_valid (wmem_req_valid),
      .wmem_req_ready (wmem_req_ready),
      .wmem_req_rw    (wmem_req_rw),
      .wmem_req_addr  (wmem_req_addr),
      .wmem_req_wdata (wmem_req_wdata),
      .wmem_resp_valid(wmem_resp_valid),
      .wmem_resp_rdata(wmem_resp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory returns word = address one cycle after each handshake.
   always @(negedge clk) begin
      wmem_resp_valid = 1'b0;
      wmem_resp_rdata = '0;
      if (!rst_n) begin
         hs_coming      = 0;
         wmem_req_ready = 1'b1;
      end else begin
         if (hs_coming) begin
            hs_coming = 0;
            if (hs_beat != suppress_beat) begin
               wmem_resp_valid = 1'b1;
               wmem_resp_rdata = hs_addr;
            end
         end
         if (inj_idle && line_req_ready) begin
            wmem_resp_valid = 1'b1;
            wmem_resp_rdata = 32'hDEAD_BEEF;
         end
         if (wmem_req_valid && (beat_idx == stall_beat) && (stall_left > 0)) begin
            wmem_req_ready = 1'b0;
            stall_left--;
            stall_addr.push_back(wmem_req_addr);
            if (inj_issue) begin
               wmem_resp_valid = 1'b1;
               wmem_resp_rdata = 32'hDEAD_BEEF;
            end
         end else begin
            wmem_req_ready = 1'b1;
         end
         if (wmem_req_valid && wmem_req_ready) begin
            hs_coming = 1;
            hs_addr   = wmem_req_addr;
            hs_beat   = beat_idx;
            log_addr.push_back(wmem_req_addr);
            log_data.push_back(wmem_req_wdata);
            log_rw.push_back(wmem_req_rw);
            beat_idx++;
         end
      end
   end

   task automatic clear_model();
      beat_idx      = 0;
      stall_beat    = -1;
      stall_left    = 0;
      suppress_beat = -1;
      inj_idle      = 0;
      inj_issue     = 0;
      log_addr.delete();
      log_data.delete();
      log_rw.delete();
      stall_addr.delete();
   endtask

   task automatic send_req(input logic rw, input logic [31:0] addr, input logic [127:0] wdata);
      bit ok;
      ok = 0;
      @(negedge clk);
      line_req_valid = 1'b1;
      line_req_rw    = rw;
      line_req_addr  = addr;
      line_req_wdata = wdata;
      for (int i = 0; i < 50; i++) begin
         if (line_req_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL req_accept: ready=%b want 1 within 50 cycles", line_req_ready);
      end
      @(posedge clk);
      #1;
      line_req_valid = 1'b0;
   endtask

   task automatic wait_resp();
      lat = -1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (line_resp_valid) begin
            lat       = c;
            got_err   = line_resp_err;
            got_rdata = line_resp_rdata;
            break;
         end
      end
   endtask

   task automatic check_pulse_end(input string name);
      @(negedge clk);
      total++;
      if ({line_resp_valid, line_req_ready} !== 2'b01) begin
         bad++;
         $display("FAIL %s_after: valid,ready=%b want 01", name, {line_resp_valid, line_req_ready});
      end
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      line_req_valid = 1'b0;
      line_req_rw    = 1'b0;
      line_req_addr  = '0;
      line_req_wdata = '0;
      #23;
      total++;
      if ({line_req_ready, line_resp_valid, line_resp_err, wmem_req_valid, wmem_req_rw} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {line_req_ready, line_resp_valid, line_resp_err, wmem_req_valid, wmem_req_rw});
      end
      total++;
      if ({wmem_req_addr, wmem_req_wdata} !== 64'h0) begin
         bad++;
         $display("FAIL reset_payload: got %h want 0", {wmem_req_addr, wmem_req_wdata});
      end
      total++;
      if (line_resp_rdata !== 128'h0) begin
         bad++;
         $display("FAIL reset_rdata: got %h want 0", line_resp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (line_req_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_before_edge: got %b want 0", line_req_ready);
      end
      @(negedge clk);
      total++;
      if (line_req_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_first_edge: got %b want 1", line_req_ready);
      end
   endtask

   task automatic test_read();
      clear_model();
      send_req(1'b0, 32'h0000_0047, '0);
      wait_resp();
      total++;
      if (lat !== 9) begin
         bad++;
         $display("FAIL read_latency: got %0d want 9", lat);
      end
      total++;
      if (got_err !== 1'b0) begin
         bad++;
         $display("FAIL read_err: got %b want 0", got_err);
      end
      total++;
      if (got_rdata !== 128'h0000004C_00000048_00000044_00000040) begin
         bad++;
         $display("FAIL read_rdata: got %h want 0000004c000000480000004400000040", got_rdata);
      end
      check_pulse_end("read");
      total++;
      if (log_addr.size() !== 4) begin
         bad++;
         $display("FAIL read_beats: got %0d want 4", log_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({log_rw[i], log_addr[i]} !== {1'b0, 32'h40 + 32'(4 * i)}) begin
               bad++;
               $display("FAIL read_beat%0d: got rw=%b addr=%h want rw=0 addr=%h",
                        i, log_rw[i], log_addr[i], 32'h40 + 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_write();
      clear_model();
      send_req(1'b1, 32'h0000_0080, 128'h00000033_00000022_00000011_00000000);
      wait_resp();
      total++;
      if ({lat, got_err} !== {32'd9, 1'b0}) begin
         bad++;
         $display("FAIL write_resp: got lat=%0d err=%b want lat=9 err=0", lat, got_err);
      end
      total++;
      if (got_rdata !== 128'h0000004C_00000048_00000044_00000040) begin
         bad++;
         $display("FAIL write_rdata_hold: got %h want previous read line", got_rdata);
      end
      check_pulse_end("write");
      total++;
      if (log_addr.size() !== 4) begin
         bad++;
         $display("FAIL write_beats: got %0d want 4", log_addr.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if ({log_rw[i], log_addr[i], log_data[i]} !==
                {1'b1, 32'h80 + 32'(4 * i), 32'(8'h11 * i)}) begin
               bad++;
               $display("FAIL write_beat%0d: got rw=%b addr=%h data=%h want rw=1 addr=%h data=%h",
                        i, log_rw[i], log_addr[i], log_data[i],
                        32'h80 + 32'(4 * i), 32'(8'h11 * i));
            end
         end
      end
   endtask

   task automatic test_stall();
      clear_model();
      stall_beat = 2;
      stall_left = 3;
      send_req(1'b0, 32'h0000_0040, '0);
      wait_resp();
      total++;
      if ({lat, got_err} !== {32'd12, 1'b0}) begin
         bad++;
         $display("FAIL stall_resp: got lat=%0d err=%b want lat=12 err=0", lat, got_err);
      end
      total++;
      if (got_rdata !== 128'h0000004C_00000048_00000044_00000040) begin
         bad++;
         $display("FAIL stall_rdata: got %h want 0000004c000000480000004400000040", got_rdata);
      end
      total++;
      if (stall_addr.size() !== 3) begin
         bad++;
         $display("FAIL stall_cycles: got %0d want 3", stall_addr.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (stall_addr[i] !== 32'h48) begin
               bad++;
               $display("FAIL stall_addr%0d: got %h want 00000048", i, stall_addr[i]);
            end
         end
      end
      check_pulse_end("stall");
   endtask

   task automatic test_timeout();
      clear_model();
      suppress_beat = 1;
      send_req(1'b0, 32'h0000_0200, '0);
      wait_resp();
      total++;
      if ({lat, got_err} !== {32'd14, 1'b1}) begin
         bad++;
         $display("FAIL timeout_resp: got lat=%0d err=%b want lat=14 err=1", lat, got_err);
      end
      total++;
      if (wmem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL timeout_wmem_valid: got %b want 0", wmem_req_valid);
      end
      check_pulse_end("timeout");
   endtask

   task automatic test_reset_mid();
      bit seen;
      clear_model();
      seen = 0;
      send_req(1'b0, 32'h0000_0040, '0);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (wmem_req_valid && (wmem_req_addr == 32'h48)) begin
            seen = 1;
            break;
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL rstmid_reach_beat2: got 0 want 1");
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({line_req_ready, line_resp_valid, line_resp_err, wmem_req_valid, wmem_req_rw,
           wmem_req_addr, wmem_req_wdata, line_resp_rdata} !== '0) begin
         bad++;
         $display("FAIL rstmid_outputs: got ctrl=%b addr=%h wdata=%h rdata=%h want all 0",
                  {line_req_ready, line_resp_valid, line_resp_err, wmem_req_valid, wmem_req_rw},
                  wmem_req_addr, wmem_req_wdata, line_resp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (line_resp_valid) seen = 1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL rstmid_no_resp: got pulse want none");
      end
      clear_model();
      send_req(1'b0, 32'h0000_0000, '0);
      wait_resp();
      total++;
      if ({lat, got_err} !== {32'd9, 1'b0}) begin
         bad++;
         $display("FAIL rstmid_new_resp: got lat=%0d err=%b want lat=9 err=0", lat, got_err);
      end
      total++;
      if (got_rdata !== 128'h0000000C_00000008_00000004_00000000) begin
         bad++;
         $display("FAIL rstmid_new_rdata: got %h want 0000000c000000080000000400000000", got_rdata);
      end
      check_pulse_end("rstmid");
   endtask

   task automatic test_spurious();
      clear_model();
      inj_idle = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({line_req_ready, line_resp_valid, line_resp_rdata} !==
             {2'b10, 128'h0000000C_00000008_00000004_00000000}) begin
            bad++;
            $display("FAIL spur_idle%0d: got ready=%b valid=%b rdata=%h want ready=1 valid=0 rdata unchanged",
                     i, line_req_ready, line_resp_valid, line_resp_rdata);
         end
      end
      inj_idle   = 0;
      stall_beat = 0;
      stall_left = 2;
      inj_issue  = 1;
      send_req(1'b0, 32'h0000_0100, '0);
      wait_resp();
      total++;
      if ({lat, got_err} !== {32'd11, 1'b0}) begin
         bad++;
         $display("FAIL spur_issue_resp: got lat=%0d err=%b want lat=11 err=0", lat, got_err);
      end
      total++;
      if (got_rdata !== 128'h0000010C_00000108_00000104_00000100) begin
         bad++;
         $display("FAIL spur_issue_rdata: got %h want 0000010c000001080000010400000100", got_rdata);
      end
      check_pulse_end("spur");
      inj_issue = 0;
   endtask

   initial begin
      wmem_req_ready  = 1'b1;
      wmem_resp_valid = 1'b0;
      wmem_resp_rdata = '0;
      test_reset();
      test_read();
      test_write();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_spurious();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/mem_line_bridge.md
MEM_LINE_BRIDGE -- requirements
Module: mem_line_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning word-memory data width.
REQ-003 SHALL have parameter LINE_BYTES, default 16, meaning cache line size; LINE_WIDTH = LINE_BYTES*8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max cycles waited per beat.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 line_req_valid  in  1  cache line request from L1/victim top.
REQ-008 line_req_rw  in  1  0 = line read (refill), 1 = line write (writeback).
REQ-009 line_req_addr  in  ADDR_WIDTH  line byte address.
REQ-010 line_req_wdata  in  LINE_WIDTH  writeback line; word k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 line_req_ready  out  1  bridge can accept a request.
REQ-012 line_resp_valid  out  1  one-cycle completion pulse.
REQ-013 line_resp_rdata  out  LINE_WIDTH  assembled refill line, same word order as REQ-010.
REQ-014 line_resp_err  out  1  qualifies line_resp_valid; 1 = beat timeout abort.
REQ-015 wmem_req_valid / wmem_req_ready  out / in  1 / 1  word request handshake.
REQ-016 wmem_req_rw, wmem_req_addr, wmem_req_wdata  out  1, ADDR_WIDTH, DATA_WIDTH  word request payload.
REQ-017 wmem_resp_valid, wmem_resp_rdata  in  1, DATA_WIDTH  word response (read data or write ack).

Function
REQ-018 BEATS = LINE_BYTES/(DATA_WIDTH/8); SHALL be 4 at defaults.
REQ-019 Request accepted when line_req_valid && line_req_ready; addr (low log2(LINE_BYTES) bits forced 0), rw, wdata captured.
REQ-020 FSM states: IDLE, ISSUE, WAIT, DONE; line_req_ready = 1 only in IDLE (registered).
REQ-021 IDLE -> ISSUE on accept; beat counter cleared to 0.
REQ-022 ISSUE: wmem_req_valid held 1 with payload stable until wmem_req_ready; payload addr = base + k*(DATA_WIDTH/8), wdata = word k, rw = captured rw.
REQ-023 ISSUE -> WAIT on handshake cycle; wmem_req_valid deasserted next cycle.
REQ-024 WAIT: on wmem_resp_valid, read stores wmem_resp_rdata into word k; write discards data; then k == BEATS-1 -> DONE, else k+1, -> ISSUE.
REQ-025 wmem_resp_valid outside WAIT SHALL be ignored (no state/data change).
REQ-026 DONE: line_resp_valid = 1 for exactly one cycle, line_resp_err = 0, -> IDLE.
REQ-027 Minimum latency: accept to line_resp_valid = 2*BEATS+1 cycles with ready=1 and 1-cycle response (9 at defaults).
REQ-028 Timeout counter (8 bits min) clears on entering ISSUE/WAIT, increments each cycle in ISSUE or WAIT; reaching TIMEOUT_CYCLES -> DONE with line_resp_err = 1, wmem_req_valid dropped.
REQ-029 line_resp_rdata SHALL hold its value until next read completes; on error, unreceived words undefined but not X-propagating (reset-cleared register).
REQ-030 line_req_valid while busy SHALL be ignored; requester must hold until ready.

Reset
REQ-031 rst_n low: state IDLE, counters 0, line_req_ready 0, line_resp_valid 0, line_resp_err 0, line_resp_rdata 0, wmem_req_valid 0, wmem_req_rw 0, wmem_req_addr 0, wmem_req_wdata 0.
REQ-032 line_req_ready SHALL rise on the first clock edge after rst_n release.
REQ-033 Reset mid-transfer SHALL abort immediately with no line_resp_valid issued afterwards for that request.

Structure
REQ-034 Package mem_bridge_pkg SHALL hold state enum typedef and BEATS/offset-width localparam functions.
REQ-035 Single module, no sub-modules; instantiated between cache top mem_* port and word memory.

Verification
REQ-036 Read 0x40, memory returns word = addr, ready=1, 1-cycle resp -> rdata {0x4C,0x48,0x44,0x40} (MSW first), valid at cycle 9, err 0.
REQ-037 Write 0x80 wdata {0x33,0x22,0x11,0x00} -> word writes 0x80=0x00, 0x84=0x11, 0x88=0x22, 0x8C=0x33 in order, then resp_valid.
REQ-038 wmem_req_ready low 3 cycles on beat 2 -> payload stable throughout, completion at cycle 12.
REQ-039 No response on beat 1, TIMEOUT_CYCLES=10 -> line_resp_valid with err=1 after 10 WAIT cycles, ready returns next cycle.
REQ-040 rst_n pulsed during beat 2 -> all outputs 0, no later resp pulse; new read 0x00 completes correctly.
REQ-041 Spurious wmem_resp_valid in IDLE and ISSUE -> no state change, rdata unchanged.
